gate_model_bist_ctrl: RTL

GATE_MODEL_BIST_CTRL -- requirements
Module: gate_model_bist_ctrl

---
 rtl/gate_model_bist_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/gate_model_bist_ctrl.sv
// LFSR-pattern / MISR-signature self-test sequencer for a 16-in, 10-out gate model.
// Build option GATE_BIST_SETTLE_EN adds one SETTLE cycle per pattern (3 instead of 2).
module gate_model_bist_ctrl #(
  parameter int NUM_PATTERNS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] seed,
  input  logic [9:0]  golden,
  input  logic [9:0]  resp_in,
  output logic [15:0] pat_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [9:0]  signature
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
`ifdef GATE_BIST_SETTLE_EN
  localparam logic [2:0] S_SETTLE  = 3'd5;
`endif

  localparam logic [15:0] LAST = 16'(NUM_PATTERNS - 1);

  logic [2:0]  state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt, lfsr_step;
  logic [15:0] count;
  logic [9:0]  misr, misr_fold;
  logic        running;
  logic        kill;

  assign running   = (state != S_IDLE) && (state != S_DONE);
  assign kill      = abort && running;
  assign signature = misr;

  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    misr_fold    = {misr[8:0], misr[9]} ^ resp_in;
    misr_fold[3] = misr[2] ^ misr[9] ^ resp_in[3];
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt = S_APPLY;
        lfsr_nxt  = (seed == 16'h0000) ? 16'h0001 : seed;
      end
`ifdef GATE_BIST_SETTLE_EN
      S_APPLY:   state_nxt = S_SETTLE;
      S_SETTLE:  state_nxt = S_CAPTURE;
`else
      S_APPLY:   state_nxt = S_CAPTURE;
`endif
      S_CAPTURE: begin
        lfsr_nxt  = lfsr_step;
        state_nxt = (count == LAST) ? S_DONE : S_APPLY;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // Abort freezes the LFSR and MISR where they are so the partial signature stays visible.
    if (kill) begin
      state_nxt = S_IDLE;
      lfsr_nxt  = lfsr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lfsr    <= 16'h0001;
      pat_out <= 16'h0000;
      misr    <= 10'h000;
      count   <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      busy  <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done  <= (state_nxt == S_DONE);
      if (state_nxt == S_APPLY) pat_out <= lfsr_nxt;
      if (kill) begin
        pass <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) pass <= 1'b0;
          S_LOAD: begin
            misr  <= 10'h000;
            count <= 16'h0000;
          end
          S_CAPTURE: begin
            misr  <= misr_fold;
            count <= 16'(count + 16'd1);
            // Verdict is registered alongside the last fold so it is valid during the done pulse.
            if (count == LAST) pass <= (misr_fold == golden);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
